// File: rtl/axi_pkg.sv
// Shared AXI-lite definitions for the 2:1 crossbar: bus widths, response codes
// and the crossbar transaction-owner state encoding.
package axi_pkg;

    localparam int AXI_ADDR_BUS = 32;
    localparam int AXI_DATA_BUS = 32;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        WR1  = 2'd3
    } xbar_state_t;

endpackage

// File: rtl/axi_lite_xbar_2to1_chk.sv
// Protocol checker for the slave side of the crossbar: once a valid is
// presented it must stay up until the slave accepts it.
module axi_lite_xbar_2to1_chk (
    input logic clk,
    input logic rst_n,
    input logic arvalid,
    input logic arready,
    input logic awvalid,
    input logic awready,
    input logic wvalid,
    input logic wready
);

    a_ar_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (arvalid && !arready) |=> arvalid)
        else $error("xbar: arvalid withdrawn before handshake");

    a_aw_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (awvalid && !awready) |=> awvalid)
        else $error("xbar: awvalid withdrawn before handshake");

    a_w_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (wvalid && !wready) |=> wvalid)
        else $error("xbar: wvalid withdrawn before handshake");

endmodule

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. last_grant remembers who won most recently
// so a tie goes to the other requester; it resets to 1 so M0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_grant_q;
    logic last_grant_d;

    // One-hot grant from the current requests and the tie-break history
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // History only moves when the owner FSM actually accepts the grant
    always_comb begin
        last_grant_d = last_grant_q;
        if (advance && (gnt != 2'b00)) begin
            last_grant_d = gnt[1];
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Tie-break history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/axi_lite_xbar_2to1.sv
// AXI-lite 2:1 crossbar: IFU (read-only) and LSU share one SRAM slave, one whole
// transaction at a time, with a one-cycle arbitration bubble between owners.
module axi_lite_xbar_2to1
    import axi_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_BUS,
    parameter int DATA_W = AXI_DATA_BUS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     m0_araddr,
    input  logic                  m0_arvalid,
    input  logic                  m0_rready,
    output logic                  m0_arready,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [1:0]            m0_rresp,
    input  logic [ADDR_W-1:0]     m1_araddr,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    input  logic                  m1_arvalid,
    input  logic                  m1_awvalid,
    input  logic                  m1_wvalid,
    input  logic                  m1_rready,
    input  logic                  m1_bready,
    output logic                  m1_arready,
    output logic                  m1_awready,
    output logic                  m1_wready,
    output logic                  m1_rvalid,
    output logic                  m1_bvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic [1:0]            m1_bresp,
    output logic [ADDR_W-1:0]     s_araddr,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_arvalid,
    output logic                  s_awvalid,
    output logic                  s_wvalid,
    output logic                  s_rready,
    output logic                  s_bready,
    input  logic                  s_arready,
    input  logic                  s_awready,
    input  logic                  s_wready,
    input  logic                  s_rvalid,
    input  logic                  s_bvalid,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic [1:0]            s_bresp
);

    localparam int STRB_W = DATA_W / 8;

    xbar_state_t state_q;
    xbar_state_t state_d;
    logic        ar_done_q, ar_done_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;
    logic [1:0]  req_s;
    logic [1:0]  gnt_s;
    logic        advance_s;

    assign req_s = {m1_awvalid | m1_arvalid, m0_arvalid};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_s),
        .advance (advance_s),
        .gnt     (gnt_s)
    );

    // Owner state and per-channel handshake-done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next owner: grant from IDLE (LSU write beats LSU read), release on final response
    always_comb begin
        state_d   = state_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        advance_s = 1'b0;
        case (state_q)
            IDLE: begin
                ar_done_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (gnt_s[0]) begin
                    state_d   = RD0;
                    advance_s = 1'b1;
                end else if (gnt_s[1]) begin
                    state_d   = m1_awvalid ? WR1 : RD1;
                    advance_s = 1'b1;
                end else begin
                    state_d   = IDLE;
                end
            end
            RD0, RD1: begin
                if (s_rvalid && s_rready) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end else if (s_arvalid && s_arready) begin
                    ar_done_d = 1'b1;
                end else begin
                    ar_done_d = ar_done_q;
                end
            end
            WR1: begin
                if (s_bvalid && s_bready) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | (s_awvalid && s_awready);
                    w_done_d  = w_done_q  | (s_wvalid  && s_wready);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Channel routing for the current owner; everything unrouted is held at zero
    always_comb begin
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = {DATA_W{1'b0}};
        m0_rresp   = OKAY;
        m1_arready = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_rvalid  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_rdata   = {DATA_W{1'b0}};
        m1_rresp   = OKAY;
        m1_bresp   = OKAY;
        s_araddr   = {ADDR_W{1'b0}};
        s_awaddr   = {ADDR_W{1'b0}};
        s_wdata    = {DATA_W{1'b0}};
        s_wstrb    = {STRB_W{1'b0}};
        s_arvalid  = 1'b0;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_rready   = 1'b0;
        s_bready   = 1'b0;
        case (state_q)
            RD0: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid & ~ar_done_q;
                m0_arready = s_arready & ~ar_done_q;
                m0_rvalid  = s_rvalid;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                s_rready   = m0_rready;
            end
            RD1: begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid & ~ar_done_q;
                m1_arready = s_arready & ~ar_done_q;
                m1_rvalid  = s_rvalid;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                s_rready   = m1_rready;
            end
            WR1: begin
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid & ~aw_done_q;
                m1_awready = s_awready & ~aw_done_q;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid & ~w_done_q;
                m1_wready  = s_wready & ~w_done_q;
                m1_bvalid  = s_bvalid;
                m1_bresp   = s_bresp;
                s_bready   = m1_bready;
            end
            default: begin
                s_arvalid  = 1'b0;
            end
        endcase
    end

    axi_lite_xbar_2to1_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .arvalid (s_arvalid),
        .arready (s_arready),
        .awvalid (s_awvalid),
        .awready (s_awready),
        .wvalid  (s_wvalid),
        .wready  (s_wready)
    );

endmodule

// File: tb/tb_axi_lite_xbar_2to1.sv
// Directed bench for axi_lite_xbar_2to1: behavioural SRAM slave with adjustable
// read latency, grant-order log, and hand-computed expected values.
module tb_axi_lite_xbar_2to1;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata;
    logic        m0_arvalid, m0_rready, m1_arvalid, m1_awvalid, m1_wvalid, m1_rready, m1_bready;
    logic [3:0]  m1_wstrb;
    logic        m0_arready, m0_rvalid, m1_arready, m1_awready, m1_wready, m1_rvalid, m1_bvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
    logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
    logic        s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
    logic [1:0]  s_rresp, s_bresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_xbar_2to1 dut (
        .clk(clk), .rst_n(rst_n),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_rready(m0_rready),
        .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m1_araddr(m1_araddr), .m1_awaddr(m1_awaddr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_arvalid(m1_arvalid), .m1_awvalid(m1_awvalid), .m1_wvalid(m1_wvalid),
        .m1_rready(m1_rready), .m1_bready(m1_bready),
        .m1_arready(m1_arready), .m1_awready(m1_awready), .m1_wready(m1_wready),
        .m1_rvalid(m1_rvalid), .m1_bvalid(m1_bvalid),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_bresp(m1_bresp),
        .s_araddr(s_araddr), .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_arvalid(s_arvalid), .s_awvalid(s_awvalid), .s_wvalid(s_wvalid),
        .s_rready(s_rready), .s_bready(s_bready),
        .s_arready(s_arready), .s_awready(s_awready), .s_wready(s_wready),
        .s_rvalid(s_rvalid), .s_bvalid(s_bvalid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_bresp(s_bresp)
    );

    // ---------------- SRAM slave model ----------------
    assign s_arready = 1'b1;
    assign s_awready = 1'b1;
    assign s_wready  = 1'b1;

    int          rd_lat;
    logic [1:0]  slv_rresp;
    logic [31:0] mem [0:255];
    logic        rd_busy, aw_got, w_got;
    int          rd_cnt, b_cnt, w_hs_cnt;
    logic [7:0]  rd_idx, aw_idx;
    logic [31:0] w_data, last_wdata;
    logic [3:0]  w_strb, last_wstrb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[0]     <= 32'h0000_0013;
            mem[64]    <= 32'hCAFE_0001;
            mem[128]   <= 32'h1111_2222;
            rd_busy    <= 1'b0;
            rd_cnt     <= 0;
            rd_idx     <= 8'h0;
            s_rvalid   <= 1'b0;
            s_rdata    <= 32'h0;
            s_rresp    <= 2'b00;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            aw_idx     <= 8'h0;
            w_data     <= 32'h0;
            w_strb     <= 4'h0;
            last_wdata <= 32'h0;
            last_wstrb <= 4'h0;
            s_bvalid   <= 1'b0;
            s_bresp    <= 2'b00;
            b_cnt      <= 0;
            w_hs_cnt   <= 0;
        end else begin
            if (s_arvalid && s_arready) begin
                rd_busy <= 1'b1;
                rd_idx  <= s_araddr[9:2];
                rd_cnt  <= rd_lat;
            end else if (rd_busy && !s_rvalid) begin
                if (rd_cnt <= 1) begin
                    s_rvalid <= 1'b1;
                    s_rdata  <= mem[rd_idx];
                    s_rresp  <= slv_rresp;
                end else begin
                    rd_cnt <= rd_cnt - 1;
                end
            end else if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
                s_rdata  <= 32'h0;
                rd_busy  <= 1'b0;
            end
            if (aw_got && w_got && !s_bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb[b]) mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
                last_wdata <= w_data;
                last_wstrb <= w_strb;
                s_bvalid   <= 1'b1;
                s_bresp    <= OKAY;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
                b_cnt    <= b_cnt + 1;
            end
            if (s_awvalid && s_awready) begin
                aw_got <= 1'b1;
                aw_idx <= s_awaddr[9:2];
            end
            if (s_wvalid && s_wready) begin
                w_got    <= 1'b1;
                w_data   <= s_wdata;
                w_strb   <= s_wstrb;
                w_hs_cnt <= w_hs_cnt + 1;
            end
        end
    end

    // ---------------- grant log and quiet monitor ----------------
    // grant ids: 0 = M0 read, 1 = M1 read, 2 = M1 write
    int   glog [0:63];
    int   gn = 0;
    int   cyc = 0;
    int   ar1_cyc = 0;
    int   b1_cyc = 0;
    int   quiet_viol = 0;
    logic m0_busy = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gn < 64) begin
            if (m0_arvalid && m0_arready) begin
                glog[gn] <= 0; gn <= gn + 1;
            end else if (m1_awvalid && m1_awready) begin
                glog[gn] <= 2; gn <= gn + 1;
            end else if (m1_arvalid && m1_arready) begin
                glog[gn] <= 1; gn <= gn + 1;
            end
        end
        if (m1_arvalid && m1_arready) ar1_cyc <= cyc;
        if (m1_bvalid && m1_bready)   b1_cyc  <= cyc;
    end

    always @(negedge clk) begin
        if (m0_busy && (m1_arready || m1_rvalid || m1_awready || m1_wready || m1_bvalid ||
                        (m1_rdata != 32'h0) || (m1_rresp != 2'b00) || (m1_bresp != 2'b00)))
            quiet_viol <= quiet_viol + 1;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic m_read(input int m, input logic [31:0] addr,
                          output logic [31:0] data, output logic [1:0] resp);
        int n;
        data = 32'hFFFF_FFFF;
        resp = 2'b11;
        if (m == 0) begin
            m0_busy = 1'b1; m0_araddr = addr; m0_arvalid = 1'b1;
        end else begin
            m1_araddr = addr; m1_arvalid = 1'b1;
        end
        #1;
        n = 0;
        while (!((m == 0) ? m0_arready : m1_arready) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk("ar_wait_timeout", 32'(n >= 200), 32'd0);
        @(posedge clk);
        @(negedge clk);
        if (m == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
        #1;
        n = 0;
        while (!((m == 0) ? m0_rvalid : m1_rvalid) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk("r_wait_timeout", 32'(n >= 200), 32'd0);
        data = (m == 0) ? m0_rdata : m1_rdata;
        resp = (m == 0) ? m0_rresp : m1_rresp;
        if (m == 0) m0_busy = 1'b0;
    endtask

    task automatic m1_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input bit w_early, output logic [1:0] bresp, output bit w_forced);
        int n;
        bit aw_hs, w_hs;
        w_forced = 1'b1;
        m1_wdata = data; m1_wstrb = strb; m1_wvalid = 1'b1;
        if (w_early) begin
            @(negedge clk); #1;
        end
        m1_awaddr = addr; m1_awvalid = 1'b1;
        n = 0;
        while ((m1_awvalid || m1_wvalid) && n < 200) begin
            #1;
            aw_hs = m1_awvalid && m1_awready;
            w_hs  = m1_wvalid && m1_wready;
            @(negedge clk); #1; n++;
            if (w_hs) begin
                if (s_wvalid !== 1'b0) w_forced = 1'b0;
                m1_wvalid = 1'b0;
            end
            if (aw_hs) m1_awvalid = 1'b0;
        end
        chk("aw_w_timeout", 32'(n >= 200), 32'd0);
        #1;
        n = 0;
        while (!m1_bvalid && n < 200) begin
            @(negedge clk); #1; n++;
        end
        chk("b_wait_timeout", 32'(n >= 200), 32'd0);
        bresp = m1_bresp;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] d0, d1, f0d, f1d;
    logic [1:0]  r0, r1, f0r, f1r, br;
    bit          wf;
    int          gs, qv0, bc0, wc0, n;

    initial begin
        rst_n = 1'b0;
        m0_araddr = 32'h0; m0_arvalid = 1'b0; m0_rready = 1'b1;
        m1_araddr = 32'h0; m1_awaddr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        m1_arvalid = 1'b0; m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        m1_rready = 1'b1; m1_bready = 1'b1;
        rd_lat = 3; slv_rresp = OKAY;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // reset state
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_last_grant", 32'(dut.u_arb.last_grant_q), 32'd1);
        chk("rst_handshakes", 32'({m0_arready, m0_rvalid, m1_arready, m1_awready, m1_wready,
                                   m1_rvalid, m1_bvalid, s_arvalid, s_awvalid, s_wvalid,
                                   s_rready, s_bready}), 32'd0);

        // single M0 fetch, M1 stays silent
        qv0 = quiet_viol;
        m_read(0, 32'h8000_0000, d0, r0);
        chk("t1_rdata", d0, 32'h0000_0013);
        chk("t1_rresp", 32'(r0), 32'd0);
        chk("t1_m1_quiet", 32'(quiet_viol - qv0), 32'd0);

        // fresh reset restores last_grant=1 so M0 wins the simultaneous tie
        do_reset();
        gs = gn; qv0 = quiet_viol;
        fork
            m_read(0, 32'h8000_0000, d0, r0);
            m_read(1, 32'h8000_0100, d1, r1);
        join
        @(negedge clk);
        chk("t2_grant_count", 32'(gn - gs), 32'd2);
        chk("t2_first_grant", 32'(glog[gs]), 32'd0);
        chk("t2_second_grant", 32'(glog[gs + 1]), 32'd1);
        chk("t2_m0_rdata", d0, 32'h0000_0013);
        chk("t2_m1_rdata", d1, 32'hCAFE_0001);
        chk("t2_m1_quiet", 32'(quiet_viol - qv0), 32'd0);

        // M1 write with W leading AW by one cycle
        bc0 = b_cnt; wc0 = w_hs_cnt;
        m1_write(32'h8000_0200, 32'hDEAD_BEEF, 4'b0011, 1'b1, br, wf);
        repeat (3) @(negedge clk); #1;
        chk("t3_slave_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("t3_slave_wstrb", 32'(last_wstrb), 32'h3);
        chk("t3_b_count", 32'(b_cnt - bc0), 32'd1);
        chk("t3_w_handshakes", 32'(w_hs_cnt - wc0), 32'd1);
        chk("t3_bresp", 32'(br), 32'd0);
        chk("t3_wvalid_forced", 32'(wf), 32'd1);
        chk("t3_no_extra_b", 32'(m1_bvalid), 32'd0);
        m_read(1, 32'h8000_0200, d1, r1);
        chk("t3_readback", d1, 32'h1111_BEEF);

        // both masters continuously requesting; M1 went last, so M0 leads
        gs = gn;
        fork
            begin
                for (int i = 0; i < 4; i++) m_read(0, 32'h8000_0000, f0d, f0r);
            end
            begin
                for (int j = 0; j < 4; j++) m_read(1, 32'h8000_0100, f1d, f1r);
            end
        join
        @(negedge clk);
        chk("t4_grant_count", 32'(gn - gs), 32'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("t4_grant_%0d", k), 32'(glog[gs + k]), 32'(k % 2));
        chk("t4_m0_last_rdata", f0d, 32'h0000_0013);
        chk("t4_m1_last_rdata", f1d, 32'hCAFE_0001);

        // M1 write and read together: write first, read two cycles after B
        gs = gn;
        fork
            m1_write(32'h8000_0300, 32'hA5A5_5A5A, 4'hF, 1'b0, br, wf);
            m_read(1, 32'h8000_0300, d1, r1);
        join
        @(negedge clk);
        chk("t5_first_grant", 32'(glog[gs]), 32'd2);
        chk("t5_second_grant", 32'(glog[gs + 1]), 32'd1);
        chk("t5_rdata", d1, 32'hA5A5_5A5A);
        chk("t5_ar_after_b", 32'(ar1_cyc - b1_cyc), 32'd2);

        // slave error response passes through untouched
        slv_rresp = SLVERR;
        m_read(0, 32'h8000_0000, d0, r0);
        slv_rresp = OKAY;
        chk("t6_slverr_rresp", 32'(r0), 32'h2);
        chk("t6_slverr_rdata", d0, 32'h0000_0013);

        // asynchronous reset while RD1 waits on a stalled slave
        rd_lat = 20;
        m1_araddr = 32'h8000_0100; m1_arvalid = 1'b1;
        #1;
        n = 0;
        while (!m1_arready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("t7_ar_timeout", 32'(n >= 50), 32'd0);
        @(posedge clk);
        @(negedge clk);
        m1_arvalid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t7_pre_state", 32'(dut.state_q), 32'(RD1));
        rst_n = 1'b0;
        #1;
        chk("t7_rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("t7_rst_ar_done", 32'(dut.ar_done_q), 32'd0);
        chk("t7_rst_handshakes", 32'({m0_arready, m0_rvalid, m1_arready, m1_awready, m1_wready,
                                      m1_rvalid, m1_bvalid, s_arvalid, s_awvalid, s_wvalid,
                                      s_rready, s_bready}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_lat = 3;
        @(negedge clk); #1;
        m_read(0, 32'h8000_0000, d0, r0);
        chk("t7_post_rdata", d0, 32'h0000_0013);
        chk("t7_post_rresp", 32'(r0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_lite_xbar_2to1.md
Name: axi_lite_xbar_2to1

Overview:
- Two-master, one-slave AXI-lite arbiter that shares the single instruction/data SRAM slave between the IFU and the LSU.
- M0 is the IFU, read-only. M1 is the LSU, read and write.
- Sits between the core fetch/load-store units and the SRAM model.
- Serialises whole transactions: one outstanding AR→R or AW/W→B at a time.
- Round-robin fairness between the two masters.

Parameters:
- ADDR_W, 32, address width (matches `AXI_ADDR_BUS)
- DATA_W, 32, data width (matches `AXI_DATA_BUS); strobe width is DATA_W/8

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous and active-low
- m0_araddr  in  ADDR_W  IFU read address
- m0_arvalid, m0_rready  in  1  IFU AR valid / R ready
- m0_arready, m0_rvalid  out  1  IFU AR ready / R valid
- m0_rdata  out  DATA_W  IFU read data
- m0_rresp  out  2  IFU read response
- m1_araddr, m1_awaddr  in  ADDR_W  LSU read/write address
- m1_wdata  in  DATA_W  LSU write data
- m1_wstrb  in  DATA_W/8  LSU byte strobes
- m1_arvalid, m1_awvalid, m1_wvalid, m1_rready, m1_bready  in  1  LSU valids/readies
- m1_arready, m1_awready, m1_wready, m1_rvalid, m1_bvalid  out  1  LSU readies/valids
- m1_rdata  out  DATA_W  LSU read data
- m1_rresp, m1_bresp  out  2  LSU responses
- s_araddr, s_awaddr  out  ADDR_W  slave read/write address
- s_wdata  out  DATA_W  slave write data
- s_wstrb  out  DATA_W/8  slave byte strobes
- s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready  out  1  slave valids/readies
- s_arready, s_awready, s_wready, s_rvalid, s_bvalid  in  1  slave readies/valids
- s_rdata  in  DATA_W  slave read data
- s_rresp, s_bresp  in  2  slave responses

Behaviour:
- Requests: req0 = m0_arvalid. req1 = m1_awvalid | m1_arvalid.
  - If M1 asserts both, the write is served first.
- FSM states: IDLE, RD0, RD1, WR1. Registers: state, last_grant (1 bit).
- Reset (rst_n low, asynchronous): state=IDLE, last_grant=1, so M0 wins the first tie.
  - All master-side readies/valids and all slave-side valids/readies are 0 while in IDLE.
  - All data/resp outputs are 0 while not routed.
- IDLE arbitration:
  - Only one requester: grant it.
  - Both requesting: grant the one that is not last_grant.
  - On grant, register state (RD0, RD1 or WR1) and update last_grant.
  - No slave signal is driven in IDLE, giving a fixed 1-cycle arbitration bubble.
- RDx:
  - Combinationally route the owner's AR to the slave and the slave's R back to the owner.
  - Non-owner sees arready=0 and rvalid=0.
  - Track ar_done (set on s_arvalid & s_arready). After ar_done, s_arvalid is forced 0.
  - Exit to IDLE on s_rvalid & s_rready.
- WR1:
  - Route AW, W and B between M1 and the slave. AW and W may handshake in either order or in the same cycle.
  - Track aw_done and w_done; each valid is forced 0 after its handshake.
  - Exit to IDLE on s_bvalid & s_bready.
- While M1 is in WR1, m1_arready=0; any pending M1 AR is served in a later grant.
- A master that drops valid before its handshake is a protocol violation. The block does not recover; the assertion fires in simulation.
- Response codes pass through unchanged. No address decoding, no error generation.
- Reset mid-transaction: immediate return to IDLE and all done flags clear. The slave is reset by the same rst_n.
- Throughput: one transaction per (1 + slave latency + 1) cycles minimum. No back-to-back without the IDLE bubble.
- Fairness: with both masters continuously requesting, grants strictly alternate M0, M1, M0, ...

Decomposition:
- Shared package axi_pkg:
  - state enum xbar_state_t {IDLE, RD0, RD1, WR1}
  - resp constants OKAY=2'b00, SLVERR=2'b10
  - the existing bus width macros
- One sub-module, rr_arb2: 2-input round-robin grant logic plus the last_grant register. Inputs: req[1:0], advance. Output: one-hot gnt.

Test Plan:
- After reset, M0 arvalid, araddr=0x8000_0000, slave returns 0x0000_0013 after 3 cycles → M0 gets rdata 0x13, rresp 0. M1 outputs stay 0 throughout.
- M0 and M1 both assert arvalid in the same cycle (addresses 0x8000_0000 and 0x8000_0100) → M0 is served first, then M1. Grant order M0, M1. Each M1 signal is quiet until M0's R handshake completes.
- M1 write: AW 0x8000_0200, W 0xDEAD_BEEF, wstrb 4'b0011.
  - W valid one cycle before AW → slave sees the data with strobe 0x3 intact.
  - Exactly one B reaches M1, with bresp 0.
  - s_wvalid drops after its handshake.
- Continuous requests from both masters for 8 transactions → grants alternate M0, M1, M0, ... Neither master waits more than one other transaction.
- M1 asserts awvalid+wvalid and arvalid together → WR1 completes (B seen) before the M1 read is granted. The read returns the just-written data.
- rst_n pulled low mid-RD1, while the slave is stalling → state is IDLE and all valids/readies are 0 in the same cycle. After release, a fresh M0 read completes normally.
